// File: rtl/shift_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_burst_arbiter
//  Purpose  : Round-robin arbiter between two burst requesters (A, B) that
//             share a single WIDTH-bit left/right shift register. A granted
//             burst is played out serially on LeftCtrl/LeftIn or
//             RightCtrl/RightIn, one shift per cycle. A one-cycle done pulse
//             follows the last shift.
//  Revision : 1.0  initial release
// ============================================================================
module shift_burst_arbiter #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    // requester A
    input  logic             a_valid,
    output logic             a_ready,
    input  logic             a_dir,
    input  logic [CNT_W-1:0] a_len,
    input  logic [WIDTH-1:0] a_data,
    // requester B
    input  logic             b_valid,
    output logic             b_ready,
    input  logic             b_dir,
    input  logic [CNT_W-1:0] b_len,
    input  logic [WIDTH-1:0] b_data,
    // shift register controls (sampled by the register on the falling edge)
    output logic             LeftCtrl,
    output logic             LeftIn,
    output logic             RightCtrl,
    output logic             RightIn,
    // status
    output logic             busy,
    output logic             grant_id,
    output logic             done
);

    // Longest burst the register can take; longer requests are clamped to it.
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;        // 0: A wins a tie, 1: B wins a tie
    logic               dir_q, dir_d;        // direction of the burst in flight
    logic [WIDTH-1:0]   data_q, data_d;      // bits still to be shifted out
    logic [CNT_W-1:0]   cnt_q, cnt_d;        // shifts left after the current one
    logic               grant_q, grant_d;
    logic               left_ctrl_q, left_ctrl_d;
    logic               left_in_q, left_in_d;
    logic               right_ctrl_q, right_ctrl_d;
    logic               right_in_q, right_in_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    // Arbitration and request mux
    logic               pick_b;
    logic               accept;
    logic               sel_dir;
    logic [CNT_W-1:0]   sel_len;
    logic [CNT_W-1:0]   len_eff;
    logic [WIDTH-1:0]   sel_data;
    logic               shift_now;           // a shift is issued in the next cycle
    logic               shift_bit;           // serial bit for that shift

    // Pick the winner: a lone valid wins, a tie goes to the pointer's favourite.
    always_comb begin
        pick_b   = b_valid && (!a_valid || ptr_q);
        a_ready  = (state_q == S_IDLE) && !Reset && a_valid && !pick_b;
        b_ready  = (state_q == S_IDLE) && !Reset && pick_b;
        accept   = a_ready || b_ready;
        sel_dir  = pick_b ? b_dir  : a_dir;
        sel_len  = pick_b ? b_len  : a_len;
        sel_data = pick_b ? b_data : a_data;
        len_eff  = (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
    end

    // Next-state logic: the first shift is issued in the accept cycle itself,
    // so the counter is loaded with the number of shifts that remain after it.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        dir_d     = dir_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        shift_now = 1'b0;
        shift_bit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ptr_d   = ~pick_b;
                    grant_d = pick_b;
                    dir_d   = sel_dir;
                    if (len_eff == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_SHIFT;
                        shift_now = 1'b1;
                        // Right shifts feed LSB first, left shifts MSB first.
                        shift_bit = sel_dir ? sel_data[0] : sel_data[WIDTH-1];
                        data_d    = sel_dir ? (sel_data >> 1) : (sel_data << 1);
                        cnt_d     = len_eff - CNT_W'(1);
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    shift_now = 1'b1;
                    shift_bit = dir_q ? data_q[0] : data_q[WIDTH-1];
                    data_d    = dir_q ? (data_q >> 1) : (data_q << 1);
                    cnt_d     = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values, derived from the next state so every pin is a flop.
    always_comb begin
        left_ctrl_d  = shift_now && !dir_d;
        left_in_d    = shift_now && !dir_d && shift_bit;
        right_ctrl_d = shift_now && dir_d;
        right_in_d   = shift_now && dir_d && shift_bit;
        done_d       = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            dir_q        <= 1'b0;
            data_q       <= '0;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            left_ctrl_q  <= 1'b0;
            left_in_q    <= 1'b0;
            right_ctrl_q <= 1'b0;
            right_in_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            dir_q        <= dir_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            left_ctrl_q  <= left_ctrl_d;
            left_in_q    <= left_in_d;
            right_ctrl_q <= right_ctrl_d;
            right_in_q   <= right_in_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign LeftCtrl  = left_ctrl_q;
    assign LeftIn    = left_in_q;
    assign RightCtrl = right_ctrl_q;
    assign RightIn   = right_in_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_burst_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_shift_burst_arbiter
//  Purpose  : Scoreboard bench for shift_burst_arbiter with an attached
//             behavioural shift register sampling on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_burst_arbiter;
    localparam int W  = 6;
    localparam int CW = 3;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          a_valid = 1'b0, a_dir = 1'b0, b_valid = 1'b0, b_dir = 1'b0;
    logic [CW-1:0] a_len = '0, b_len = '0;
    logic [W-1:0]  a_data = '0, b_data = '0;
    logic          a_ready, b_ready;
    logic          LeftCtrl, LeftIn, RightCtrl, RightIn, busy, grant_id, done;

    shift_burst_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clock(Clock), .Reset(Reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_dir(a_dir), .a_len(a_len), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dir(b_dir), .b_len(b_len), .b_data(b_data),
        .LeftCtrl(LeftCtrl), .LeftIn(LeftIn), .RightCtrl(RightCtrl), .RightIn(RightIn),
        .busy(busy), .grant_id(grant_id), .done(done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic         id;
        logic         dir;
        int           n;
        logic [W-1:0] stream;
        logic [W-1:0] bits;
        int           cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t act_q[$];
    int   compared = 0, mismatched = 0;
    int   cyc = 0, hs_total = 0, inv_err = 0, clr_cnt = 0;
    int   clr_seen_p = 0, clr_seen_m = 0;
    logic [W-1:0] model_bits = '0;
    logic [W-1:0] reg_bits = '0;
    int           n_m = 0;
    logic [W-1:0] s_m = '0;
    logic         d_m = 1'b0;

    // Expected side: on every handshake, predict the burst from the request fields.
    always @(posedge Clock) begin : push
        rec_t         e;
        int           n;
        logic [CW-1:0] len;
        logic [W-1:0]  data;
        logic          bt;
        cyc++;
        if (clr_cnt != clr_seen_p) begin model_bits = '0; clr_seen_p = clr_cnt; end
        if ((a_valid && a_ready) || (b_valid && b_ready)) begin
            e.id   = b_valid && b_ready;
            e.dir  = e.id ? b_dir : a_dir;
            len    = e.id ? b_len : a_len;
            data   = e.id ? b_data : a_data;
            n      = (int'(len) > W) ? W : int'(len);
            e.n    = n;
            e.stream = '0;
            for (int i = 0; i < n; i++) begin
                bt = e.dir ? data[i] : data[W-1-i];
                e.stream = {e.stream[W-2:0], bt};
                model_bits = e.dir ? {bt, model_bits[W-1:1]} : {model_bits[W-2:0], bt};
            end
            e.bits = model_bits;
            e.cyc  = cyc;
            exp_q.push_back(e);
            hs_total++;
        end
    end

    // Actual side: attached shift register plus burst collector and invariants.
    always @(negedge Clock) begin : mon
        rec_t a;
        if (clr_cnt != clr_seen_m) begin reg_bits = '0; clr_seen_m = clr_cnt; end
        if (LeftCtrl && RightCtrl) inv_err++;
        if (LeftIn && !LeftCtrl) inv_err++;
        if (RightIn && !RightCtrl) inv_err++;
        if (a_ready && b_ready) inv_err++;
        if ((LeftCtrl || RightCtrl || done) && !busy) inv_err++;
        if (Reset) begin
            n_m = 0; s_m = '0; d_m = 1'b0;
        end else begin
            if (LeftCtrl) begin
                reg_bits = {reg_bits[W-2:0], LeftIn};
                s_m = {s_m[W-2:0], LeftIn}; n_m++; d_m = 1'b0;
            end else if (RightCtrl) begin
                reg_bits = {RightIn, reg_bits[W-1:1]};
                s_m = {s_m[W-2:0], RightIn}; n_m++; d_m = 1'b1;
            end
            if (done) begin
                a.id = grant_id; a.dir = d_m; a.n = n_m; a.stream = s_m;
                a.bits = reg_bits; a.cyc = cyc;
                act_q.push_back(a);
                n_m = 0; s_m = '0; d_m = 1'b0;
            end
        end
    end

    task automatic send(input bit id, input bit dir, input int len,
                        input logic [W-1:0] data, output bit ok);
        @(negedge Clock);
        if (id) begin b_valid = 1; b_dir = dir; b_len = len[CW-1:0]; b_data = data; end
        else    begin a_valid = 1; a_dir = dir; a_len = len[CW-1:0]; a_data = data; end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (id ? b_ready : a_ready) begin ok = 1; break; end
            @(negedge Clock);
        end
        @(posedge Clock);
        @(negedge Clock);
        if (id) b_valid = 0; else a_valid = 0;
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL handshake_timeout: ready=0 required=1");
        end
    endtask

    task automatic wait_acts(input int n, output bit ok);
        for (int i = 0; i < 200 && act_q.size() < n; i++) @(negedge Clock);
        ok = (act_q.size() >= n) && (exp_q.size() >= n);
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL done_timeout: bursts=%0d required=%0d", act_q.size(), n);
        end
    endtask

    task automatic test_reset;
        Reset = 1; a_valid = 1; b_valid = 1; a_len = 3'd2; b_len = 3'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock); #1;
            compared++;
            if ({a_ready, b_ready} !== 2'b00) begin
                mismatched++;
                $display("FAIL reset_ready: got %b required 00", {a_ready, b_ready});
            end
            compared++;
            if ({LeftCtrl, LeftIn, RightCtrl, RightIn, busy, grant_id, done} !== 7'b0) begin
                mismatched++;
                $display("FAIL reset_outputs: got %b required 0000000",
                         {LeftCtrl, LeftIn, RightCtrl, RightIn, busy, grant_id, done});
            end
        end
        a_valid = 0; b_valid = 0;
        @(negedge Clock);
        Reset = 0;
    endtask

    task automatic test_left;
        rec_t e, a; bit ok;
        clr_cnt++;
        send(0, 0, 6, 6'b101101, ok);
        wait_acts(1, ok);
        if (ok) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            compared++; if (a.id !== 1'b0) begin mismatched++; $display("FAIL left_grant: got %b required 0", a.id); end
            compared++; if (a.n != 6) begin mismatched++; $display("FAIL left_count: got %0d required 6", a.n); end
            compared++; if (a.stream !== 6'b101101 || a.stream !== e.stream) begin mismatched++; $display("FAIL left_stream: got %b required %b", a.stream, e.stream); end
            compared++; if (a.bits !== 6'b101101) begin mismatched++; $display("FAIL left_bits: got %b required 101101", a.bits); end
            compared++; if (a.cyc - e.cyc != 6) begin mismatched++; $display("FAIL left_latency: got %0d required 6", a.cyc - e.cyc); end
        end
    endtask

    task automatic test_right;
        rec_t e, a; bit ok;
        clr_cnt++;
        send(1, 1, 6, 6'b110010, ok);
        wait_acts(1, ok);
        if (ok) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            compared++; if (a.id !== 1'b1 || a.dir !== 1'b1) begin mismatched++; $display("FAIL right_grant_dir: got %b%b required 11", a.id, a.dir); end
            compared++; if (a.n != 6) begin mismatched++; $display("FAIL right_count: got %0d required 6", a.n); end
            compared++; if (a.stream !== 6'b010011 || a.stream !== e.stream) begin mismatched++; $display("FAIL right_stream: got %b required 010011", a.stream); end
            compared++; if (a.bits !== 6'b110010) begin mismatched++; $display("FAIL right_bits: got %b required 110010", a.bits); end
        end
    endtask

    task automatic test_alternate;
        rec_t e, a; bit ok; int base; int prev;
        logic exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        clr_cnt++;
        @(negedge Clock);
        a_dir = 0; a_len = 3'd2; a_data = 6'b110000;
        b_dir = 1; b_len = 3'd2; b_data = 6'b000011;
        base = hs_total;
        a_valid = 1; b_valid = 1;
        for (int i = 0; i < 100 && hs_total < base + 4; i++) @(negedge Clock);
        a_valid = 0; b_valid = 0;
        wait_acts(4, ok);
        prev = 0;
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front(); a = act_q.pop_front();
                compared++; if (a.id !== exp_id[k] || e.id !== exp_id[k]) begin mismatched++; $display("FAIL alt_grant[%0d]: got %b required %b", k, a.id, exp_id[k]); end
                compared++; if (a.n != 2 || a.stream !== e.stream || a.stream !== 6'b000011) begin mismatched++; $display("FAIL alt_burst[%0d]: got n=%0d s=%b required n=2 s=000011", k, a.n, a.stream); end
                if (k > 0) begin
                    compared++; if (a.cyc - prev != 4) begin mismatched++; $display("FAIL alt_period[%0d]: got %0d required 4", k, a.cyc - prev); end
                end
                prev = a.cyc;
            end
        end
    endtask

    task automatic test_len_bounds;
        rec_t e, a; bit ok;
        clr_cnt++;
        send(0, 0, 0, 6'b111111, ok);
        wait_acts(1, ok);
        if (ok) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            compared++; if (a.n != 0) begin mismatched++; $display("FAIL len0_count: got %0d required 0", a.n); end
            compared++; if (a.cyc != e.cyc) begin mismatched++; $display("FAIL len0_latency: got %0d required 0", a.cyc - e.cyc); end
        end
        send(0, 0, 7, 6'b011010, ok);
        wait_acts(1, ok);
        if (ok) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            compared++; if (a.n != 6) begin mismatched++; $display("FAIL len7_left_count: got %0d required 6", a.n); end
            compared++; if (a.bits !== 6'b011010 || a.stream !== e.stream) begin mismatched++; $display("FAIL len7_left_bits: got %b required 011010", a.bits); end
        end
        send(1, 1, 7, 6'b100101, ok);
        wait_acts(1, ok);
        if (ok) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            compared++; if (a.n != 6 || a.cyc - e.cyc != 6) begin mismatched++; $display("FAIL len7_right_count: got %0d required 6", a.n); end
            compared++; if (a.bits !== 6'b100101) begin mismatched++; $display("FAIL len7_right_bits: got %b required 100101", a.bits); end
        end
    endtask

    task automatic test_reset_mid;
        rec_t e, a; bit ok;
        clr_cnt++;
        @(negedge Clock);
        a_dir = 0; a_len = 3'd6; a_data = 6'b111111; a_valid = 1;
        b_dir = 1; b_len = 3'd2; b_data = 6'b000001;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            #1; if (a_ready) begin ok = 1; break; end
            @(negedge Clock);
        end
        @(posedge Clock);                       // accept, cycle k
        @(negedge Clock); a_valid = 0; b_valid = 1;   // shift 1
        @(negedge Clock);                               // shift 2
        @(negedge Clock); Reset = 1;                    // shift 3
        @(negedge Clock); a_valid = 1;                  // first cycle after reset sampled
        compared++;
        if ({LeftCtrl, RightCtrl, done, busy} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: got %b required 0000", {LeftCtrl, RightCtrl, done, busy});
        end
        @(negedge Clock); Reset = 0;
        compared++;
        if (act_q.size() != 0 || !ok) begin
            mismatched++;
            $display("FAIL reset_mid_no_done: got %0d done pulses required 0", act_q.size());
        end
        compared++;
        if (exp_q.size() != 1) begin
            mismatched++;
            $display("FAIL reset_mid_pending: got %0d required 1", exp_q.size());
        end
        exp_q.delete();
        #1;
        compared++;
        if ({a_ready, b_ready} !== 2'b10) begin
            mismatched++;
            $display("FAIL reset_mid_tiebreak: got %b required 10", {a_ready, b_ready});
        end
        @(posedge Clock);
        @(negedge Clock); a_valid = 0; b_valid = 0;
        wait_acts(1, ok);
        if (ok) begin
            e = exp_q.pop_front(); a = act_q.pop_front();
            compared++; if (a.id !== 1'b0 || a.n != 6 || a.stream !== e.stream) begin mismatched++; $display("FAIL reset_mid_next: got id=%b n=%0d required id=0 n=6", a.id, a.n); end
        end
    endtask

    task automatic test_invariants;
        repeat (3) @(negedge Clock);
        compared++;
        if (inv_err != 0) begin
            mismatched++;
            $display("FAIL output_invariants: got %0d violations required 0", inv_err);
        end
    endtask

    initial begin
        test_reset;
        test_left;
        test_right;
        test_alternate;
        test_len_bounds;
        test_reset_mid;
        test_invariants;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
